// File: rtl/noc_traffic_node.sv
// NoC traffic generator/checker endpoint: bursts packets out, checks packets in.
// Define NOC_TEST_BACKPRESSURE_EN to drive receive_ready from a 16-bit LFSR.
`ifndef Noc_ID_X_Width
`define Noc_ID_X_Width 4
`endif
`ifndef Noc_ID_Y_Width
`define Noc_ID_Y_Width 4
`endif
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_traffic_node #(
  parameter logic [`Noc_ID_X_Width-1:0] X_ID      = '0,
  parameter logic [`Noc_ID_Y_Width-1:0] Y_ID      = '0,
  parameter logic [`Noc_ID_X_Width-1:0] DEST_X_ID = '0,
  parameter logic [`Noc_ID_Y_Width-1:0] DEST_Y_ID = '0,
  parameter int VC_NUM        = 2,
  parameter int SEND_VC       = 0,
  parameter int PAYLOAD_FLITS = 2,
  parameter int PKT_COUNT     = 4,
  parameter int GAP_CYCLES    = 0
) (
  input  logic                       noc_clk,
  input  logic                       noc_rst_n,
  input  logic                       send_start,
  output logic [VC_NUM-1:0]          sender_valid,
  input  logic [VC_NUM-1:0]          sender_ready,
  output logic [`Noc_Data_Width-1:0] sender_flit,
  output logic                       sender_is_header,
  output logic                       sender_is_tail,
  input  logic [VC_NUM-1:0]          receive_valid,
  output logic [VC_NUM-1:0]          receive_ready,
  input  logic [`Noc_Data_Width-1:0] receive_flit,
  input  logic                       receive_is_header,
  input  logic                       receive_is_tail,
  output logic                       tx_done,
  output logic [15:0]                rx_pkt_count,
  output logic [15:0]                err_count
);
  localparam int XW  = `Noc_ID_X_Width;
  localparam int YW  = `Noc_ID_Y_Width;
  localparam int DW  = `Noc_Data_Width;
  localparam int PAD = DW - 2*XW - 2*YW - 16;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_BODY = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;
  localparam logic [7:0] LEN      = 8'(PAYLOAD_FLITS);
  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_FLITS-1);
  localparam logic [7:0] LAST_SEQ = 8'(PKT_COUNT-1);
  localparam logic [7:0] GAP_M1   = 8'(GAP_CYCLES-1);

  function automatic logic [DW-1:0] f_hdr(input logic [7:0] seq);
    f_hdr = DW'({X_ID, Y_ID, DEST_X_ID, DEST_Y_ID, LEN, seq}) << PAD;
  endfunction

  function automatic logic [DW-1:0] f_body(input logic [7:0] seq,
                                           input logic [7:0] k);
    f_body = DW'({seq, k});
  endfunction

  logic [1:0]    r_state;
  logic [7:0]    r_seq, r_idx, r_gap;
  logic          r_valid, r_hdr, r_tail, r_tx_done;
  logic [DW-1:0] r_flit;
  logic          w_fire;

  assign w_fire = r_valid && sender_ready[SEND_VC];

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_state   <= S_IDLE;
      r_seq     <= '0;
      r_idx     <= '0;
      r_gap     <= '0;
      r_valid   <= 1'b0;
      r_hdr     <= 1'b0;
      r_tail    <= 1'b0;
      r_tx_done <= 1'b0;
      r_flit    <= '0;
    end else begin
      r_tx_done <= 1'b0;
      unique case (r_state)
        S_IDLE: if (send_start) begin
          r_state <= S_HDR;
          r_seq   <= '0;
          r_valid <= 1'b1;
          r_flit  <= f_hdr(8'd0);
          r_hdr   <= 1'b1;
          r_tail  <= 1'b0;
        end
        S_HDR: if (w_fire) begin
          r_state <= S_BODY;
          r_idx   <= '0;
          r_flit  <= f_body(r_seq, 8'd0);
          r_hdr   <= 1'b0;
          r_tail  <= (LAST_IDX == 8'd0);
        end
        S_BODY: if (w_fire) begin
          if (r_tail) begin
            r_tail <= 1'b0;
            if (r_seq == LAST_SEQ) begin
              r_valid   <= 1'b0;
              r_state   <= S_IDLE;
              r_tx_done <= 1'b1;
            end else if (GAP_CYCLES > 0) begin
              r_valid <= 1'b0;
              r_state <= S_GAP;
              r_gap   <= GAP_M1;
              r_seq   <= r_seq + 8'd1;
            end else begin
              r_state <= S_HDR;
              r_seq   <= r_seq + 8'd1;
              r_flit  <= f_hdr(r_seq + 8'd1);
              r_hdr   <= 1'b1;
            end
          end else begin
            r_idx  <= r_idx + 8'd1;
            r_flit <= f_body(r_seq, r_idx + 8'd1);
            r_tail <= (r_idx + 8'd1 == LAST_IDX);
          end
        end
        default: begin
          if (r_gap == 8'd0) begin
            r_state <= S_HDR;
            r_valid <= 1'b1;
            r_flit  <= f_hdr(r_seq);
            r_hdr   <= 1'b1;
          end else begin
            r_gap <= r_gap - 8'd1;
          end
        end
      endcase
    end
  end

  assign sender_valid     = VC_NUM'(r_valid) << SEND_VC;
  assign sender_flit      = r_flit;
  assign sender_is_header = r_hdr;
  assign sender_is_tail   = r_tail;
  assign tx_done          = r_tx_done;

  logic [VC_NUM-1:0] r_rdy;
  assign receive_ready = r_rdy;

`ifdef NOC_TEST_BACKPRESSURE_EN
  localparam logic [15:0] SEED = 16'hACE1 ^ 16'({X_ID, Y_ID});
  logic [15:0] r_lfsr;
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_lfsr <= SEED;
      r_rdy  <= '0;
    end else begin
      r_lfsr <= {r_lfsr[14:0],
                 r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      r_rdy  <= r_lfsr[VC_NUM-1:0];
    end
  end
`else
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) r_rdy <= '0;
    else            r_rdy <= '1;
  end
`endif

  logic [XW-1:0] w_dx;
  logic [YW-1:0] w_dy;
  logic [7:0]    w_len, w_sq;
  logic          w_dst_bad;
  assign w_sq      = receive_flit[PAD +: 8];
  assign w_len     = receive_flit[PAD+8 +: 8];
  assign w_dy      = receive_flit[PAD+16 +: YW];
  assign w_dx      = receive_flit[PAD+16+YW +: XW];
  assign w_dst_bad = {w_dx, w_dy} != {X_ID, Y_ID};

  logic [2*VC_NUM-1:0] w_err_vec;
  logic [VC_NUM-1:0]   w_good_vec;

  // Independent checker per VC; errors are summed so simultaneous hits all count.
  for (genvar v = 0; v < VC_NUM; v++) begin : g_rx
    logic       r_st, r_perr;
    logic [7:0] r_len, r_sq, r_ix;
    logic       w_take, w_mis, w_last, w_tbad, w_g;
    logic [1:0] w_e;

    assign w_take = receive_valid[v] && r_rdy[v];
    assign w_mis  = receive_flit != f_body(r_sq, r_ix);
    assign w_last = r_ix == r_len - 8'd1;
    assign w_tbad = receive_is_tail != w_last;

    always_comb begin
      w_e = '0;
      w_g = 1'b0;
      if (w_take) begin
        if (receive_is_header) begin
          w_e = {1'b0, r_st} + {1'b0, w_dst_bad};
        end else if (!r_st) begin
          w_e = 2'd1;
        end else begin
          w_e = {1'b0, w_mis} + {1'b0, w_tbad};
          w_g = receive_is_tail && w_last && !w_mis && !r_perr;
        end
      end
    end

    assign w_err_vec[2*v +: 2] = w_e;
    assign w_good_vec[v]       = w_g;

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
        r_st   <= 1'b0;
        r_perr <= 1'b0;
        r_len  <= '0;
        r_sq   <= '0;
        r_ix   <= '0;
      end else if (w_take) begin
        if (receive_is_header) begin
          r_st   <= 1'b1;
          r_len  <= w_len;
          r_sq   <= w_sq;
          r_ix   <= '0;
          r_perr <= w_dst_bad;
        end else if (r_st) begin
          r_ix   <= r_ix + 8'd1;
          r_perr <= r_perr | w_mis | w_tbad;
          if (receive_is_tail || w_last) r_st <= 1'b0;
        end
      end
    end
  end

  logic [4:0]  w_esum;
  logic [3:0]  w_gsum;
  logic [16:0] w_enext, w_gnext;
  logic [15:0] r_err, r_good;

  always_comb begin
    w_esum = '0;
    w_gsum = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      w_esum = w_esum + 5'(w_err_vec[2*v +: 2]);
      w_gsum = w_gsum + 4'(w_good_vec[v]);
    end
  end

  assign w_enext = {1'b0, r_err} + 17'(w_esum);
  assign w_gnext = {1'b0, r_good} + 17'(w_gsum);

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      r_err  <= '0;
      r_good <= '0;
    end else begin
      r_err  <= w_enext[16] ? 16'hFFFF : w_enext[15:0];
      r_good <= w_gnext[16] ? 16'hFFFF : w_gnext[15:0];
    end
  end

  assign err_count    = r_err;
  assign rx_pkt_count = r_good;

  logic w_unused;
  assign w_unused = ^sender_ready;
endmodule

// File: tb/tb_noc_traffic_node.sv
// Directed bench for noc_traffic_node: sender timing, stalls, gaps,
// loopback checking, error injection and mid-packet reset.
module tb_noc_traffic_node;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  s_valid, s_ready;
  logic [31:0] s_flit;
  logic        s_hdr, s_tail;
  logic [1:0]  rv, rr;
  logic [31:0] rf;
  logic        rh, rt;
  logic        tx_done;
  logic [15:0] rx_cnt, err_cnt;
  logic        lb;
  logic [1:0]  drv_v;
  logic [31:0] drv_f;
  logic        drv_h, drv_t;

  logic        b_start;
  logic [0:0]  b_valid, b_ready, b_rr;
  logic [31:0] b_flit;
  logic        b_hdr, b_tail, b_done;
  logic [15:0] b_rx, b_err;

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  assign rv = lb ? (s_valid & s_ready) : drv_v;
  assign rf = lb ? s_flit : drv_f;
  assign rh = lb ? s_hdr  : drv_h;
  assign rt = lb ? s_tail : drv_t;

  noc_traffic_node #(
    .X_ID(4'd1), .Y_ID(4'd2), .DEST_X_ID(4'd1), .DEST_Y_ID(4'd2),
    .VC_NUM(2), .SEND_VC(1), .PAYLOAD_FLITS(2), .PKT_COUNT(2),
    .GAP_CYCLES(3)
  ) u_dut (
    .noc_clk(clk), .noc_rst_n(rst_n), .send_start(start),
    .sender_valid(s_valid), .sender_ready(s_ready),
    .sender_flit(s_flit), .sender_is_header(s_hdr),
    .sender_is_tail(s_tail), .receive_valid(rv),
    .receive_ready(rr), .receive_flit(rf),
    .receive_is_header(rh), .receive_is_tail(rt),
    .tx_done(tx_done), .rx_pkt_count(rx_cnt), .err_count(err_cnt)
  );

  noc_traffic_node #(
    .VC_NUM(1), .SEND_VC(0), .PAYLOAD_FLITS(2), .PKT_COUNT(2),
    .GAP_CYCLES(0)
  ) u_b2b (
    .noc_clk(clk), .noc_rst_n(rst_n), .send_start(b_start),
    .sender_valid(b_valid), .sender_ready(b_ready),
    .sender_flit(b_flit), .sender_is_header(b_hdr),
    .sender_is_tail(b_tail), .receive_valid(1'b0),
    .receive_ready(b_rr), .receive_flit(32'h0),
    .receive_is_header(1'b0), .receive_is_tail(1'b0),
    .tx_done(b_done), .rx_pkt_count(b_rx), .err_count(b_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] f,
                       input logic h, input logic t);
    drv_v = v;
    drv_f = f;
    drv_h = h;
    drv_t = t;
    step();
  endtask

  task automatic run_burst(input string tag);
    int n;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!tx_done && n < 60) begin
      step();
      n++;
    end
    chk(tag, 32'(tx_done), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; b_start = 1'b0;
    s_ready = 2'b11; b_ready = 1'b1; lb = 1'b0;
    drv_v = '0; drv_f = '0; drv_h = 1'b0; drv_t = 1'b0;
    #12;
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_flit", s_flit, 32'd0);
    chk("rst_flags", 32'({s_hdr, s_tail}), 32'd0);
    chk("rst_txdone", 32'(tx_done), 32'd0);
    chk("rst_rx", 32'(rx_cnt), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_rready", 32'(rr), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("rready_ones", 32'(rr), 32'd3);

    start = 1'b1;
    step();
    start = 1'b0;
    chk("a_hdr_valid", 32'(s_valid), 32'd2);
    chk("a_hdr0", s_flit, 32'h1212_0200);
    chk("a_hdr0_flags", 32'({s_hdr, s_tail}), 32'd2);
    step();
    chk("a_body0", s_flit, 32'h0000_0000);
    chk("a_body0_flags", 32'({s_hdr, s_tail}), 32'd0);
    step();
    chk("a_tail0", s_flit, 32'h0000_0001);
    chk("a_tail0_flags", 32'({s_hdr, s_tail}), 32'd1);
    for (int g = 0; g < 3; g++) begin
      step();
      chk("a_gap_low", 32'(s_valid), 32'd0);
    end
    step();
    chk("a_hdr1_valid", 32'(s_valid), 32'd2);
    chk("a_hdr1", s_flit, 32'h1212_0201);
    step();
    chk("a_body1", s_flit, 32'h0000_0100);
    step();
    chk("a_tail1", s_flit, 32'h0000_0101);
    chk("a_txdone_early", 32'(tx_done), 32'd0);
    step();
    chk("a_txdone", 32'(tx_done), 32'd1);
    chk("a_idle_valid", 32'(s_valid), 32'd0);
    step();
    chk("a_txdone_pulse", 32'(tx_done), 32'd0);

    lb = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("st_hdr", s_flit, 32'h1212_0200);
    step();
    s_ready = 2'b00;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("st_hold_flit", s_flit, 32'h0000_0000);
      chk("st_hold_valid", 32'({s_valid, s_hdr, s_tail}), 32'h8);
    end
    s_ready = 2'b11;
    step();
    chk("st_tail", s_flit, 32'h0000_0001);
    chk("st_tail_flag", 32'(s_tail), 32'd1);
    begin
      int n = 0;
      while (!tx_done && n < 60) begin
        step();
        n++;
      end
      chk("st_done", 32'(tx_done), 32'd1);
    end
    chk("lb_rx2", 32'(rx_cnt), 32'd2);
    run_burst("lb_done2");
    chk("lb_rx4", 32'(rx_cnt), 32'd4);
    chk("lb_err0", 32'(err_cnt), 32'd0);

    lb = 1'b0;
    drive(2'b01, 32'h0000_0055, 1'b0, 1'b0);
    drv_v = '0;
    chk("orphan_body", 32'(err_cnt), 32'd1);

    drive(2'b01, 32'h1212_0205, 1'b1, 1'b0);
    drive(2'b10, 32'h1212_0207, 1'b1, 1'b0);
    drive(2'b01, 32'h0000_0500, 1'b0, 1'b0);
    drive(2'b10, 32'h0000_0700, 1'b0, 1'b0);
    drive(2'b01, 32'h0000_0501, 1'b0, 1'b1);
    drive(2'b10, 32'h0000_0701, 1'b0, 1'b1);
    drv_v = '0;
    chk("ilv_rx", 32'(rx_cnt), 32'd6);
    chk("ilv_err", 32'(err_cnt), 32'd1);

    drive(2'b11, 32'h1212_0200, 1'b1, 1'b0);
    drive(2'b11, 32'h0000_DEAD, 1'b0, 1'b0);
    chk("dual_err", 32'(err_cnt), 32'd3);
    drive(2'b11, 32'h0000_0001, 1'b0, 1'b1);
    drv_v = '0;
    chk("dual_rx", 32'(rx_cnt), 32'd6);

    drive(2'b01, 32'h1233_0209, 1'b1, 1'b0);
    drv_v = '0;
    chk("dst_err", 32'(err_cnt), 32'd4);
    drive(2'b01, 32'h0000_0900, 1'b0, 1'b0);
    drive(2'b01, 32'h0000_0901, 1'b0, 1'b1);
    drv_v = '0;
    chk("dst_rx", 32'(rx_cnt), 32'd6);

    b_start = 1'b1;
    step();
    b_start = 1'b0;
    chk("b_hdr0", b_flit, 32'h0000_0200);
    step();
    chk("b_body0", b_flit, 32'h0000_0000);
    step();
    chk("b_tail0", 32'({b_tail, b_flit[7:0]}), 32'h101);
    step();
    chk("b_b2b_valid", 32'({b_valid, b_hdr}), 32'd3);
    chk("b_hdr1", b_flit, 32'h0000_0201);
    step();
    chk("b_body1", b_flit, 32'h0000_0100);
    step();
    chk("b_tail1", b_flit, 32'h0000_0101);
    step();
    chk("b_done", 32'({b_done, b_valid}), 32'd2);

    lb = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("mrst_rx", 32'(rx_cnt), 32'd0);
    chk("mrst_err", 32'(err_cnt), 32'd0);
    chk("mrst_valid", 32'(s_valid), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    run_burst("mrst_done");
    chk("mrst_rx_after", 32'(rx_cnt), 32'd2);
    chk("mrst_err_after", 32'(err_cnt), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
